// File: rtl/hslp_pkg.sv
// Shared constants and types for the sequential chunked approximate multiplier.
// The chunk width is fixed at 4 bits so that hslp_pp4 stays a small swappable cell.
package hslp_pkg;

   localparam int CHUNK = 4;

   localparam logic [1:0] MODE_EXACT = 2'd0;
   localparam logic [1:0] MODE_LOW   = 2'd1;
   localparam logic [1:0] MODE_ALL   = 2'd2;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } state_t;

   // Mode 3 is reserved and decodes the same as exact.
   function automatic logic approx_sel(input logic [1:0] mode, input logic low_half);
      case (mode)
         MODE_LOW: approx_sel = low_half;
         MODE_ALL: approx_sel = 1'b1;
         default:  approx_sel = 1'b0;
      endcase
   endfunction

endpackage

// File: rtl/hslp_pp4.sv
// 4x4 unsigned partial product; when approx is set the DROP low bits are cleared.
// This is the single definition of the approximation, kept separate so the cell can be replaced.
module hslp_pp4
   import hslp_pkg::*;
#(
   parameter int DROP = 2
) (
   input  logic [CHUNK-1:0]   x,
   input  logic [CHUNK-1:0]   y,
   input  logic               approx,
   output logic [2*CHUNK-1:0] pp
);

   if (DROP < 0 || DROP > 7) begin : g_bad_drop
      $error("hslp_pp4: DROP must be in 0..7");
   end

   localparam logic [2*CHUNK-1:0] KEEP = ~(2*CHUNK)'((1 << DROP) - 1);

   logic [2*CHUNK-1:0] exact;

   assign exact = {{CHUNK{1'b0}}, x} * {{CHUNK{1'b0}}, y};
   assign pp    = approx ? (exact & KEEP) : exact;

endmodule

// File: rtl/hslp_mul_seq.sv
// Multi-cycle WIDTHxWIDTH unsigned multiplier: one 4x4 partial product per cycle,
// a-chunk index fastest, accumulated into a 2*WIDTH-bit result.
module hslp_mul_seq
   import hslp_pkg::*;
#(
   parameter int WIDTH = 8,
   parameter int DROP  = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a,
   input  logic [WIDTH-1:0]   b,
   input  logic [1:0]         mode,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [2*WIDTH-1:0] prod
);

   localparam int N  = WIDTH / CHUNK;
   localparam int NN = N * N;
   localparam int KW = (NN > 2) ? $clog2(NN) : 1;
   localparam int PW = 2 * WIDTH;

   if ((WIDTH % CHUNK) != 0 || WIDTH < 8) begin : g_bad_width
      $error("hslp_mul_seq: WIDTH must be a multiple of 4 and at least 8");
   end

   state_t            state, state_nxt;
   logic [WIDTH-1:0]  a_q, b_q;
   logic [1:0]        mode_q;
   logic [KW-1:0]     k;
   logic [PW-1:0]     acc, prod_q;

   logic [KW-1:0]     ci, cj;
   logic [KW:0]       ij;
   logic [KW+2:0]     sh;
   logic [CHUNK-1:0]  a_chunk, b_chunk;
   logic              approx_k;
   logic [2*CHUNK-1:0] pp;
   logic [PW-1:0]     acc_sum;
   logic              accept, last;

   // Handshakes: a transfer happens on a rising edge where valid && ready are both high.
   // The producer holds in_valid and operands until in_ready; prod is stable while
   // out_valid && !out_ready.
   assign in_ready  = (state == IDLE);
   assign out_valid = (state == DONE);
   assign prod      = prod_q;
   assign accept    = in_valid && in_ready;
   assign last      = (k == KW'(NN - 1));

   assign ci      = k % KW'(N);
   assign cj      = k / KW'(N);
   assign ij      = {1'b0, ci} + {1'b0, cj};
   assign sh      = (KW+3)'(ij) * (KW+3)'(CHUNK);
   assign a_chunk = CHUNK'(a_q >> (ci * CHUNK));
   assign b_chunk = CHUNK'(b_q >> (cj * CHUNK));
   assign approx_k = approx_sel(mode_q, ij < (KW+1)'(N));

   hslp_pp4 #(.DROP(DROP)) u_pp4 (
      .x      (a_chunk),
      .y      (b_chunk),
      .approx (approx_k),
      .pp     (pp)
   );

   assign acc_sum = acc + (PW'(pp) << sh);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   always_comb begin
      state_nxt = state;
      case (state)
         IDLE:    if (in_valid)  state_nxt = RUN;
         RUN:     if (last)      state_nxt = DONE;
         DONE:    if (out_ready) state_nxt = IDLE;
         default:                state_nxt = IDLE;
      endcase
   end

   // prod_q is loaded only at the final partial product so it holds the last
   // result while the next transaction is accumulating.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         a_q    <= '0;
         b_q    <= '0;
         mode_q <= MODE_EXACT;
         k      <= '0;
         acc    <= '0;
         prod_q <= '0;
      end else if (accept) begin
         a_q    <= a;
         b_q    <= b;
         mode_q <= mode;
         k      <= '0;
         acc    <= '0;
      end else if (state == RUN) begin
         acc <= acc_sum;
         k   <= k + 1'b1;
         if (last) prod_q <= acc_sum;
      end
   end

endmodule

// File: tb/tb_hslp_mul_seq.sv
// Directed bench for hslp_mul_seq: WIDTH=8/DROP=2 approximation cases and
// WIDTH=16/DROP=0 exactness, latency, handshake and asynchronous reset.
module tb_hslp_mul_seq;

   logic clk = 1'b0;
   logic rst_n;
   always #5 clk = ~clk;

   logic        in_valid8, in_ready8, out_valid8, out_ready8;
   logic [7:0]  a8, b8;
   logic [1:0]  mode8;
   logic [15:0] prod8;

   logic        in_valid16, in_ready16, out_valid16, out_ready16;
   logic [15:0] a16, b16;
   logic [1:0]  mode16;
   logic [31:0] prod16;

   int errors;
   int checks;
   int lat;
   logic [31:0] exp_q[$];

   hslp_mul_seq #(.WIDTH(8), .DROP(2)) dut8 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid8), .in_ready(in_ready8),
      .a(a8), .b(b8), .mode(mode8), .out_valid(out_valid8),
      .out_ready(out_ready8), .prod(prod8)
   );

   hslp_mul_seq #(.WIDTH(16), .DROP(0)) dut16 (
      .clk(clk), .rst_n(rst_n), .in_valid(in_valid16), .in_ready(in_ready16),
      .a(a16), .b(b16), .mode(mode16), .out_valid(out_valid16),
      .out_ready(out_ready16), .prod(prod16)
   );

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
      end
   endtask

   // Returns at a negedge with out_valid high (or after the cycle budget).
   task automatic run8(input logic [7:0] av, input logic [7:0] bv, input logic [1:0] mv,
                       input bit hold_valid, output int l);
      @(negedge clk);
      check("in_ready8_idle", in_ready8, 1);
      in_valid8 = 1'b1; a8 = av; b8 = bv; mode8 = mv;
      @(posedge clk); #1;
      if (!hold_valid) in_valid8 = 1'b0;
      a8 = 8'h5A; b8 = 8'hC3; mode8 = 2'd2;
      l = 0;
      while (!out_valid8 && l < 40) begin
         @(negedge clk);
         l++;
      end
      in_valid8 = 1'b0;
   endtask

   task automatic take8();
      out_ready8 = 1'b1;
      @(posedge clk); #1;
      out_ready8 = 1'b0;
      @(negedge clk);
      check("out_valid8_after_take", out_valid8, 0);
      check("in_ready8_after_take", in_ready8, 1);
   endtask

   task automatic run16(input logic [15:0] av, input logic [15:0] bv, input logic [1:0] mv);
      int l;
      @(negedge clk);
      in_valid16 = 1'b1; a16 = av; b16 = bv; mode16 = mv;
      @(posedge clk); #1;
      in_valid16 = 1'b0;
      a16 = 16'hDEAD; b16 = 16'hBEEF;
      l = 0;
      while (!out_valid16 && l < 80) begin
         @(negedge clk);
         l++;
      end
      check("lat16", 64'(l), 17);
      check("prod16", prod16, exp_q.pop_front());
      out_ready16 = 1'b1;
      @(posedge clk); #1;
      out_ready16 = 1'b0;
   endtask

   initial begin
      logic [7:0]  va [4];
      logic [15:0] ra, rb;
      errors = 0; checks = 0;
      rst_n = 1'b0;
      in_valid8 = 0; a8 = '0; b8 = '0; mode8 = '0; out_ready8 = 0;
      in_valid16 = 0; a16 = '0; b16 = '0; mode16 = '0; out_ready16 = 0;
      #1;
      check("rst_in_ready8", in_ready8, 1);
      check("rst_out_valid8", out_valid8, 0);
      check("rst_prod8", prod8, 0);
      check("rst_in_ready16", in_ready16, 1);
      check("rst_out_valid16", out_valid16, 0);
      check("rst_prod16", prod16, 0);
      @(negedge clk); @(negedge clk);
      rst_n = 1'b1;

      // out_ready while idle does nothing
      out_ready8 = 1'b1;
      repeat (3) @(negedge clk);
      check("idle_out_ready_valid", out_valid8, 0);
      check("idle_out_ready_ready", in_ready8, 1);
      out_ready8 = 1'b0;

      run8(8'hFF, 8'hFF, 2'd0, 1'b0, lat);
      check("lat8_exact", 64'(lat), 5);
      check("ff_mode0", prod8, 16'hFE01);
      take8();

      // in_valid held high during RUN must not start another transaction
      run8(8'hFF, 8'hFF, 2'd2, 1'b1, lat);
      check("lat8_all", 64'(lat), 5);
      check("ff_mode2", prod8, 16'hFCE0);
      take8();

      run8(8'hFF, 8'hFF, 2'd1, 1'b0, lat);
      check("ff_mode1", prod8, 16'hFDE0);
      in_valid8 = 1'b1; a8 = 8'h11; b8 = 8'h22;
      for (int c = 0; c < 10; c++) begin
         check("hold_out_valid", out_valid8, 1);
         check("hold_prod", prod8, 16'hFDE0);
         check("hold_in_ready", in_ready8, 0);
         @(negedge clk);
      end
      in_valid8 = 1'b0;
      take8();
      check("prod_kept_idle", prod8, 16'hFDE0);

      // 0x37 * 0x5C for modes 0..3
      va[0] = 8'h13; va[1] = 8'h13; va[2] = 8'h10; va[3] = 8'h13;
      for (int m = 0; m < 4; m++) begin
         run8(8'h37, 8'h5C, 2'(m), 1'b0, lat);
         check("p37x5c", prod8, {va[m], (m == 0 || m == 3) ? 8'hC4 : 8'h94});
         take8();
      end

      run8(8'h00, 8'hAB, 2'd2, 1'b0, lat);
      check("zero_a", prod8, 0);
      take8();
      run8(8'hC9, 8'h00, 2'd1, 1'b0, lat);
      check("zero_b", prod8, 0);
      take8();

      // asynchronous reset during RUN at k=2
      @(negedge clk);
      in_valid8 = 1'b1; a8 = 8'hFF; b8 = 8'hFF; mode8 = 2'd0;
      @(posedge clk); #1;
      in_valid8 = 1'b0;
      @(posedge clk);
      @(posedge clk); #2;
      rst_n = 1'b0;
      #1;
      check("async_rst_out_valid", out_valid8, 0);
      check("async_rst_prod", prod8, 0);
      check("async_rst_in_ready", in_ready8, 1);
      @(negedge clk);
      rst_n = 1'b1;
      run8(8'h03, 8'h05, 2'd0, 1'b0, lat);
      check("post_rst_lat", 64'(lat), 5);
      check("post_rst_prod", prod8, 16'd15);
      take8();

      // WIDTH=16, DROP=0: every mode is exact
      for (int m = 0; m < 4; m++) begin
         for (int r = 0; r < 2; r++) begin
            ra = 16'($urandom_range(0, 65535));
            rb = 16'($urandom_range(0, 65535));
            exp_q.push_back(32'(ra) * 32'(rb));
            run16(ra, rb, 2'(m));
         end
      end
      ra = 16'($urandom_range(1, 65535));
      rb = 16'($urandom_range(1, 65535));
      exp_q.push_back(32'(ra) * 32'(rb));
      run16(ra, rb, 2'd3);
      exp_q.push_back(32'(ra) * 32'(rb));
      run16(ra, rb, 2'd0);
      exp_q.push_back(32'hFFFE0001);
      run16(16'hFFFF, 16'hFFFF, 2'd2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
